// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin scheduler sharing one combinational 16-bit ALU between two requesters
module alu_arbiter (
    input  logic        clk,
    input  logic        clear,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] x0,
    input  logic [15:0] y0,
    input  logic [15:0] x1,
    input  logic [15:0] y1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [2:0]  alu_op,
    input  logic [16:0] alu_out,
    input  logic        alu_err,
    output logic [16:0] result,
    output logic        valid,
    output logic        owner,
    output logic        err,
    output logic        err_state,
    output logic        busy
);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_next;
    logic last_owner, pick, take, ovf;

    always_comb begin
        take = state == IDLE && (req0 || req1);
        pick = (req0 && req1) ? ~last_owner : req1;
        ovf = alu_err && alu_op == 3'b000;
        state_next = take ? EXEC : IDLE;
    end

    assign busy = state == EXEC;

    always_ff @(posedge clk) state <= clear ? IDLE : state_next;

    always_ff @(posedge clk) begin
        if (clear) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            valid <= 1'b0;
            alu_x <= '0;
            alu_y <= '0;
            alu_op <= '0;
            result <= '0;
            owner <= 1'b0;
            err <= 1'b0;
            err_state <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            valid <= 1'b0;
            if (take) begin
                alu_x <= pick ? x1 : x0;
                alu_y <= pick ? y1 : y0;
                alu_op <= pick ? op1 : op0;
                gnt0 <= ~pick;
                gnt1 <= pick;
                last_owner <= pick;
            end
            // last_owner still names the requester whose operation is in EXEC
            if (state == EXEC) begin
                result <= alu_out;
                owner <= last_owner;
                err <= ovf;
                err_state <= err_state | ovf;
                valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
    logic clk = 0, clear = 1, req0 = 0, req1 = 0;
    logic [15:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0;
    logic [2:0] op0 = 0, op1 = 0;
    logic gnt0, gnt1, valid, owner, err, err_state, busy;
    logic [15:0] alu_x, alu_y;
    logic [2:0] alu_op;
    logic [16:0] alu_out, result;
    logic alu_err;
    int checks = 0, errors = 0, vcnt = 0, cyc = 0, vfirst = 0, vlast = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .clear(clear), .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_out(alu_out), .alu_err(alu_err), .result(result), .valid(valid),
        .owner(owner), .err(err), .err_state(err_state), .busy(busy)
    );

    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: return {a, 1'b0};
            3'd3: return {1'b0, a >> 1};
            3'd4: return {1'b0, a & b};
            3'd5: return {1'b0, a | b};
            3'd6: return {1'b0, a ^ b};
            default: return {1'b0, ~a};
        endcase
    endfunction

    // Bench ALU raises its carry flag for every op; the arbiter must keep only add overflows
    wire [16:0] alu_sum = {1'b0, alu_x} + {1'b0, alu_y};
    assign alu_out = alu_f(alu_x, alu_y, alu_op);
    assign alu_err = alu_sum[16];

    // Transaction model: one pending operation, round-robin on ties
    logic m_pend, m_last, m_who;
    logic [15:0] m_x, m_y;
    logic [2:0] m_op;
    logic e_gnt0, e_gnt1, e_valid, e_owner, e_err, e_err_state;
    logic [16:0] e_result;
    wire [16:0] m_res = alu_f(m_x, m_y, m_op);
    wire m_ovf = m_op == 3'd0 && m_res[16];
    wire m_win = (req0 && req1) ? !m_last : req1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clear) begin
            m_pend <= 0; m_last <= 1; m_who <= 0; m_x <= 0; m_y <= 0; m_op <= 0;
            e_gnt0 <= 0; e_gnt1 <= 0; e_valid <= 0; e_owner <= 0; e_err <= 0;
            e_err_state <= 0; e_result <= 0;
        end else begin
            e_gnt0 <= 0; e_gnt1 <= 0; e_valid <= 0;
            if (m_pend) begin
                e_result <= m_res; e_owner <= m_who; e_err <= m_ovf;
                e_err_state <= e_err_state | m_ovf; e_valid <= 1; m_pend <= 0;
            end else if (req0 || req1) begin
                m_who <= m_win; m_last <= m_win; m_pend <= 1;
                m_x <= m_win ? x1 : x0; m_y <= m_win ? y1 : y0; m_op <= m_win ? op1 : op0;
                e_gnt0 <= !m_win; e_gnt1 <= m_win;
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("gnt0", 32'(gnt0), 32'(e_gnt0));
        chk("gnt1", 32'(gnt1), 32'(e_gnt1));
        chk("valid", 32'(valid), 32'(e_valid));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("result", 32'(result), 32'(e_result));
        chk("owner", 32'(owner), 32'(e_owner));
        chk("err", 32'(err), 32'(e_err));
        chk("err_state", 32'(err_state), 32'(e_err_state));
        chk("alu_x", 32'(alu_x), 32'(m_x));
        chk("alu_y", 32'(alu_y), 32'(m_y));
        chk("alu_op", 32'(alu_op), 32'(m_op));
    end

    always @(negedge clk) if (valid) begin
        vcnt <= vcnt + 1;
        vlast <= cyc;
        if (vcnt == 0) vfirst <= cyc;
    end

    task automatic issue(input bit r, input logic [15:0] x, input logic [15:0] y, input logic [2:0] op, input int hold);
        bit seen = 0;
        if (r) begin req1 = 1; x1 = x; y1 = y; op1 = op; end
        else begin req0 = 1; x0 = x; y0 = y; op0 = op; end
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = r ? gnt1 : gnt0;
        end
        chk("grant_seen", 32'(seen), 32'd1);
        repeat (hold) @(negedge clk);
        if (r) req1 = 0; else req0 = 0;
    endtask

    task automatic wait_valid();
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = valid;
        end
        chk("valid_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int g[$];
        logic [16:0] seq_exp[4] = '{17'h1F5E0, 17'h001C2, 17'h00070, 17'h0FF1E};
        logic [2:0] seq_op[4] = '{3'd1, 3'd2, 3'd3, 3'd7};
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_state", 32'(err_state), 32'd0);
        clear = 0;

        issue(0, 16'h0001, 16'hFFFF, 3'd0, 0);
        wait_valid();
        chk("add_result", 32'(result), 32'h10000);
        chk("add_owner", 32'(owner), 32'd0);
        chk("add_err", 32'(err), 32'd1);
        chk("add_err_state", 32'(err_state), 32'd1);
        issue(0, 16'h0005, 16'h0003, 3'd1, 0);
        wait_valid();
        chk("sub_result", 32'(result), 32'h2);
        chk("sub_err", 32'(err), 32'd0);
        chk("sub_err_state", 32'(err_state), 32'd1);

        for (int i = 0; i < 4; i++) begin
            issue(1, 16'h00E1, 16'h0B01, seq_op[i], 0);
            wait_valid();
            chk("seq_result", 32'(result), 32'(seq_exp[i]));
            chk("seq_owner", 32'(owner), 32'd1);
            chk("seq_err", 32'(err), 32'd0);
        end

        clear = 1;
        @(negedge clk);
        clear = 0;
        req0 = 1; x0 = 16'h00FF; y0 = 16'h0F0F; op0 = 3'd4;
        req1 = 1; x1 = 16'hF0F0; y1 = 16'h3C3C; op1 = 3'd4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gnt0) g.push_back(0);
            if (gnt1) g.push_back(1);
            if (valid) chk("tie_result", 32'(result), owner ? 32'h3030 : 32'h000F);
        end
        req0 = 0; req1 = 0;
        chk("tie_count", 32'(g.size()), 32'd4);
        for (int i = 0; i < g.size(); i++) chk("tie_order", 32'(g[i]), 32'(i % 2));
        repeat (3) @(negedge clk);

        issue(0, 16'h8000, 16'h8000, 3'd0, 0);
        wait_valid();
        chk("ovf_err_state", 32'(err_state), 32'd1);
        issue(1, 16'h1111, 16'h2222, 3'd5, 0);
        clear = 1;
        @(negedge clk);
        chk("clr_valid", 32'(valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_err_state", 32'(err_state), 32'd0);
        chk("clr_result", 32'(result), 32'd0);
        chk("clr_alu_x", 32'(alu_x), 32'd0);
        clear = 0;
        req0 = 1; req1 = 1;
        @(negedge clk);
        chk("clr_tie_gnt0", 32'(gnt0), 32'd1);
        chk("clr_tie_gnt1", 32'(gnt1), 32'd0);
        req0 = 0;
        repeat (2) @(negedge clk);
        chk("loser_gnt1", 32'(gnt1), 32'd1);
        req1 = 0;
        repeat (3) @(negedge clk);

        vcnt = 0;
        issue(0, 16'h1234, 16'h0101, 3'd6, 2);
        repeat (5) @(negedge clk);
        chk("late_valid_count", 32'(vcnt), 32'd2);
        chk("late_valid_gap", 32'(vlast - vfirst), 32'd2);
        chk("late_result", 32'(result), 32'h1335);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_result", 32'(result), 32'h1335);
            chk("idle_owner", 32'(owner), 32'd0);
            chk("idle_alu_x", 32'(alu_x), 32'h1234);
            chk("idle_pulses", 32'({valid, gnt0, gnt1, busy}), 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            clear = $urandom_range(59) == 0;
            req0 = $urandom_range(2) == 0;
            req1 = $urandom_range(2) == 0;
            x0 = $urandom_range(3) == 0 ? 16'hFFFF : 16'($urandom);
            y0 = 16'($urandom);
            x1 = $urandom_range(3) == 0 ? 16'h8000 : 16'($urandom);
            y1 = $urandom_range(3) == 0 ? 16'h8000 : 16'($urandom);
            op0 = 3'($urandom);
            op1 = $urandom_range(1) == 0 ? 3'd0 : 3'($urandom);
            @(negedge clk);
        end
        clear = 0; req0 = 0; req1 = 0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin scheduler that shares the single combinational 16-bit ALU datapath (add/sub/shift/logic, 3-bit op code, 17-bit result with add-overflow flag). It accepts operation requests from two independent requesters and drives the shared ALU's operand and op-code inputs. It captures the ALU result into a registered output and keeps a sticky error state for add overflow. It sits between the requesters and the ALU instance, replacing direct testbench drive of the ALU inputs.

## Interface
- No parameters. Widths are fixed: operands 16 bits, op code 3 bits, result 17 bits.

- clk  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- req0 / req1  in  1  operation request from requester 0 / 1
- x0, y0 / x1, y1  in  16  operands from requester 0 / 1
- op0 / op1  in  3  op code from requester 0 / 1 (000 add, 001 sub, 010 shl x, 011 shr x, 100 and, 101 or, 110 xor, 111 not x)
- gnt0 / gnt1  out  1  one-cycle grant pulse: the request was accepted
- alu_x, alu_y  out  16  operands to the ALU
- alu_op  out  3  op code to the ALU
- alu_out  in  17  ALU result
- alu_err  in  1  ALU add-overflow flag
- result  out  17  captured ALU result
- valid  out  1  one-cycle pulse: result, owner and err are new
- owner  out  1  index of the requester that owns the current result
- err  out  1  overflow flag of the current result
- err_state  out  1  sticky error; set by any captured overflow, cleared only by clear
- busy  out  1  high while the FSM is not IDLE

## Operation
- The FSM has two states, IDLE and EXEC.
- IDLE: at a rising edge with req0 or req1 high:
  - Pick a winner.
  - Latch the winner's x, y and op into alu_x, alu_y and alu_op.
  - Assert the winner's gnt for the next cycle.
  - Go to EXEC.
  - With no request, stay in IDLE. All outputs hold except the pulses (gnt0, gnt1, valid), which go to 0.
- Arbitration:
  - A single request wins outright.
  - On simultaneous requests, grant the requester that is not last_owner.
  - last_owner updates on every grant.
  - Reset value of last_owner is 1, so requester 0 wins the first tie.
- EXEC: the ALU inputs are stable for the whole cycle. At the next edge:
  - result <= alu_out.
  - owner <= winner.
  - err <= alu_err and (alu_op == 000).
  - err_state <= err_state or that same value.
  - valid pulses; return to IDLE.
- Requests are not sampled in EXEC.
- Requester handshake: hold req and operands stable until gnt is seen, then deassert req within the gnt cycle. A req still high at the end of the following IDLE cycle is a new request.
- On overflow, result still carries the full 17-bit sum with bit 16 = carry. No masking.
- alu_x, alu_y and alu_op hold their last issued values until the next grant.
- clear asserted in any state, including mid-EXEC:
  - Abort the operation with no valid pulse.
  - FSM goes to IDLE.
  - All outputs go to 0; last_owner goes to 1.
  - clear has priority over requests on the same edge.

## Timing
- Reset values: gnt0, gnt1, valid, busy, err, err_state, owner = 0; result = 0; alu_x, alu_y, alu_op = 0.
- A request sampled at edge N gives:
  - gnt and busy high in cycle N+1;
  - valid and result in cycle N+2;
  - busy low in cycle N+2.
- Latency is 2 cycles from request to result.
- Throughput is one operation per 2 cycles. A request held continuously is granted every 2 cycles.
- A pending request from the losing requester is granted at the first IDLE edge after the current result (cycle N+2 edge).
- result, owner and err hold until the next valid or clear. err_state holds until clear.
- The ALU is purely combinational. Its path from alu_x/alu_y/alu_op to alu_out must close within one clk period.

## Test plan
- Single add with overflow:
  - Stimulus: req0 with x0 = 0x0001, y0 = 0xFFFF, op0 = 000.
  - Response: gnt0 at N+1; valid at N+2 with result = 0x10000, owner = 0, err = 1, err_state = 1.
  - A following sub leaves err = 0 and err_state = 1.
- Tie after reset:
  - Stimulus: req0 and req1 held high, both requesters issuing op 100 with distinct operands.
  - Response: grants alternate gnt0, gnt1, gnt0, gnt1 every 2 cycles; owner alternates to match; each result matches its requester's operands.
- Logic/shift sequence:
  - Stimulus: req1 with x1 = 0x00E1, y1 = 0x0B01 through ops 001, 010, 011, 111.
  - Response: results 0x1F5E0, 0x001C2, 0x00070, 0x0FF1E; err = 0 throughout.
  - The ALU's 17-bit subtraction wraps to 0x1F5E0.
- Clear mid-EXEC:
  - Stimulus: assert clear in the gnt cycle.
  - Response: no valid pulse; next cycle all outputs are 0 and busy = 0; err_state, if previously set, reads 0.
  - A subsequent tie is granted to requester 0.
- Late deassert:
  - Stimulus: req0 held one extra cycle after gnt0.
  - Response: re-granted as a second operation with identical result; valid pulses twice, 2 cycles apart.
- Idle hold:
  - Stimulus: no requests for 10 cycles after a result.
  - Response: result, owner, err and alu_* unchanged; valid, gnt0, gnt1 and busy stay 0.
